// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-setup blocks: controller state encoding,
// default widths and a small id-to-one-hot helper.
package rsa_pkg;

   localparam int DEF_W              = 32;
   localparam int DEF_TIMEOUT_CYCLES = 4096;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Converts a requester id into its one-hot response-valid pattern.
   function automatic logic [1:0] id_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/modinv_arbiter_rr_arb2.sv
// Two-input round-robin picker. The channel named by the priority pointer
// wins when valid, otherwise the other channel wins when valid. The grant is
// one-hot (or zero when nothing is requested). The pointer itself is owned by
// the caller.
module rr_arb2 (
   input  logic [1:0] i_valid,
   input  logic       i_ptr,
   output logic [1:0] o_grant
);

   logic w_other;

   assign w_other = ~i_ptr;

   // Priority channel first, then the other one.
   always_comb begin
      o_grant = 2'b00;
      if (i_valid[i_ptr]) begin
         o_grant[i_ptr] = 1'b1;
      end else if (i_valid[w_other]) begin
         o_grant[w_other] = 1'b1;
      end
   end

endmodule

// File: rtl/modinv_arbiter.sv
// Shares one modular-inverse unit between two requesters. Accepts a request
// round-robin, latches (a, m, id), pulses inv_start, waits for inv_done and
// returns the result on the granted channel's valid/ready response.
// Moduli below 2 are rejected without starting the unit.
// Optional build macro MODINV_TIMEOUT_EN adds a WAIT watchdog with a sticky
// inv_fault; without it WAIT is unbounded and inv_fault is tied low.
module modinv_arbiter
   import rsa_pkg::*;
#(
   parameter int W              = DEF_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic         clk,
   input  logic         rst_n,

   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_m,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic [W-1:0] rsp0_result,
   output logic         rsp0_err,

   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_m,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [W-1:0] rsp1_result,
   output logic         rsp1_err,

   output logic         inv_start,
   output logic [W-1:0] inv_a,
   output logic [W-1:0] inv_m,
   input  logic         inv_done,
   input  logic [W-1:0] inv_result,

   output logic         busy,
   output logic         inv_fault
);

   state_t       r_state;
   logic         r_ptr;
   logic         r_id;
   logic [W-1:0] r_a;
   logic [W-1:0] r_m;
   logic [W-1:0] r_result;
   logic         r_err;
   logic         r_start;
   logic [1:0]   r_rsp_vld;

   logic [1:0]   w_valid;
   logic [1:0]   w_grant;
   logic         w_idle;
   logic         w_accept;
   logic         w_gnt_id;
   logic [W-1:0] w_sel_a;
   logic [W-1:0] w_sel_m;
   logic         w_fault;
   logic         w_reject;
   logic         w_rsp_ready;

`ifdef MODINV_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_fault;

   assign w_fault   = r_fault;
   assign inv_fault = r_fault;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_fault          = 1'b0;
   assign inv_fault        = 1'b0;
`endif

   rr_arb2 u_arb (
      .i_valid (w_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant)
   );

   assign w_valid     = {req1_valid, req0_valid};
   assign w_idle      = (r_state == S_IDLE);
   assign w_accept    = w_idle & (|w_grant);
   assign w_gnt_id    = w_grant[1];
   assign w_sel_a     = w_grant[1] ? req1_a : req0_a;
   assign w_sel_m     = w_grant[1] ? req1_m : req0_m;
   // m < 2 means every bit above bit 0 is clear.
   assign w_reject    = (w_sel_m[W-1:1] == '0) | w_fault;
   assign w_rsp_ready = r_id ? rsp1_ready : rsp0_ready;

   assign req0_ready  = w_idle & w_grant[0];
   assign req1_ready  = w_idle & w_grant[1];

   assign inv_start   = r_start;
   assign inv_a       = r_a;
   assign inv_m       = r_m;
   assign busy        = ~w_idle;

   assign rsp0_valid  = r_rsp_vld[0];
   assign rsp0_result = r_rsp_vld[0] ? r_result : '0;
   assign rsp0_err    = r_rsp_vld[0] & r_err;
   assign rsp1_valid  = r_rsp_vld[1];
   assign rsp1_result = r_rsp_vld[1] ? r_result : '0;
   assign rsp1_err    = r_rsp_vld[1] & r_err;

   // Control FSM: accept, issue one start pulse, wait for done, hold response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= 1'b0;
         r_id      <= 1'b0;
         r_a       <= '0;
         r_m       <= '0;
         r_result  <= '0;
         r_err     <= 1'b0;
         r_start   <= 1'b0;
         r_rsp_vld <= 2'b00;
`ifdef MODINV_TIMEOUT_EN
         r_cnt     <= '0;
         r_fault   <= 1'b0;
`endif
      end else begin
         r_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a  <= w_sel_a;
                  r_m  <= w_sel_m;
                  r_id <= w_gnt_id;
                  if (w_reject) begin
                     r_result  <= '0;
                     r_err     <= 1'b1;
                     r_rsp_vld <= id_onehot(w_gnt_id);
                     r_state   <= S_RESP;
                  end else begin
                     r_start <= 1'b1;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // A done coincident with start cannot be ours; only WAIT listens.
`ifdef MODINV_TIMEOUT_EN
               r_cnt   <= '0;
`endif
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (inv_done) begin
                  r_result  <= inv_result;
                  r_err     <= 1'b0;
                  r_rsp_vld <= id_onehot(r_id);
                  r_state   <= S_RESP;
               end
`ifdef MODINV_TIMEOUT_EN
               else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  r_result  <= '0;
                  r_err     <= 1'b1;
                  r_fault   <= 1'b1;
                  r_rsp_vld <= id_onehot(r_id);
                  r_state   <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
`endif
            end
            S_RESP: begin
               if (w_rsp_ready) begin
                  r_rsp_vld <= 2'b00;
                  r_ptr     <= ~r_id;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/modinv_arbiter.md
Name: modinv_arbiter

Overview:
Controller that shares one modular-inverse datapath (the n0prime/qinv unit) between two requesters, e.g. CRT qinv setup and Montgomery n0' setup. It arbitrates round-robin, latches operands, and issues a single-cycle start to the unit. It then waits for the unit's done, captures the result, and returns it to the granted requester through a valid/ready response. It sits between the RSA key-setup sequencer and the inverse unit.

Parameters:
W, 32, operand/result width in bits
TIMEOUT_CYCLES, 4096, maximum WAIT cycles before fault (used only with the optional feature)

Ports:
clk  in  1  clock; all logic is rising-edge
rst_n  in  1  reset, asynchronous, active-low
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_a  in  W  value to invert (e.g. q)
req0_m  in  W  modulus (e.g. p)
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 consumes result
rsp0_result  out  W  a^-1 mod m; 0 when err is set
rsp0_err  out  1  operation rejected or failed
req1_valid, req1_ready, req1_a, req1_m, rsp1_valid, rsp1_ready, rsp1_result, rsp1_err  as channel 0
inv_start  out  1  one-cycle start pulse to inverse unit
inv_a  out  W  operand to unit; stable from ISSUE through WAIT
inv_m  out  W  modulus to unit; stable from ISSUE through WAIT
inv_done  in  1  unit result valid, single-cycle pulse
inv_result  in  W  unit result
busy  out  1  high in any state other than IDLE
inv_fault  out  1  sticky timeout fault (optional feature only; tied to 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0; priority pointer=0; operand, id and result registers cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the priority channel if it is valid, else to the other channel if valid.
  - reqN_ready is asserted combinationally for the granted channel only. Acceptance occurs on valid&&ready.
  - On acceptance, a, m and the grant id are latched.
  - If m<2: go to RESP with err=1, result=0. The unit is not started.
  - Otherwise go to ISSUE.
- ISSUE: inv_start=1 for exactly one cycle, with inv_a/inv_m from registers. Next state is WAIT.
- WAIT:
  - On inv_done, capture inv_result and go to RESP with err=0.
  - inv_done in the same cycle as inv_start is not possible. If it appears, it is ignored.
- RESP:
  - rspN_valid=1 for the latched id only. result and err are held until rspN_ready.
  - On rspN_ready, the priority pointer moves to the other channel and the FSM returns to IDLE.
- Latency: acceptance is cycle 0; inv_start is asserted in cycle 1; rsp_valid is asserted the cycle after inv_done. Error rejects give rsp_valid in cycle 1.
- Throughput: one operation in flight. Back-to-back requests from one channel alternate with any pending request from the other channel.
- Simultaneous req0/req1 out of reset: channel 0 wins.
- inv_done while not in WAIT is ignored (stale pulse).
- Reset mid-operation: the in-flight operation is discarded and no response is issued. The inverse unit has no reset, so its later inv_done arrives in IDLE and is dropped.
- reqN_ready is never asserted outside IDLE. Requesters hold valid and operands until ready.

Optional Feature:
Macro MODINV_TIMEOUT_EN.
- With the macro: a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without inv_done, the FSM goes to RESP with err=1 and result=0, and sets inv_fault. inv_fault is sticky until reset. While inv_fault=1, every accepted request goes straight to RESP with err=1 and no inv_start, so a late done cannot be mis-attributed.
- Without the macro: no counter exists, WAIT is unbounded, and inv_fault is tied to 0.

Decomposition:
- Shared package rsa_pkg: state enum (IDLE/ISSUE/WAIT/RESP), default W=32, default TIMEOUT_CYCLES.
- One natural sub-module: rr_arb2. It is a two-input round-robin picker taking valid[1:0] and the priority pointer, and producing a one-hot grant. The pointer update stays in modinv_arbiter.

Test Plan:
- Inverse-unit stub computes the true inverse with 20-cycle latency.
- req0 a=3 m=11 -> inv_start one pulse in cycle 1; rsp0_valid with result=4, err=0 at cycle 22; rsp1_valid stays 0.
- req0 (3,11) and req1 (7,26) both raised in the same cycle -> channel 0 served first (4), then channel 1 (15). A repeat of both then serves channel 0 after channel 1.
- req1 m=1 -> rsp1_err=1, result=0 in cycle 1; inv_start never asserted.
- rsp0_ready held low for 10 cycles -> rsp0_valid/result stable throughout; no req1 accepted until release.
- rst_n dropped during WAIT, then stub inv_done arrives in IDLE -> no response, busy=0; next request (3,11) returns 4.
- With MODINV_TIMEOUT_EN, TIMEOUT_CYCLES=64, stub never responds -> err=1 at cycle 66; inv_fault=1; next request is rejected with no inv_start.
